// File: rtl/risc_v_mike_mmio_arbiter_if.sv
// Requester and MMIO peripheral bundle for the MMIO arbiter.
// master: arbiter side (drives gnt/rsp/mmio strobes); slave: environment side.
interface risc_v_mike_mmio_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]    req_vld;
    logic [N_REQ-1:0]    req_we;
    logic [N_REQ*32-1:0] req_addr;
    logic [N_REQ*32-1:0] req_wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rsp_vld;
    logic                rsp_err;
    logic [31:0]         rsp_rdata;
    logic                mmio_sel;
    logic                mmio_wr_en;
    logic [31:0]         mmio_addr;
    logic [31:0]         mmio_wr_data;
    logic [31:0]         mmio_rd_data;

    modport master (
        input  req_vld, req_we, req_addr, req_wdata, mmio_rd_data,
        output gnt, rsp_vld, rsp_err, rsp_rdata,
        output mmio_sel, mmio_wr_en, mmio_addr, mmio_wr_data
    );

    modport slave (
        output req_vld, req_we, req_addr, req_wdata, mmio_rd_data,
        input  gnt, rsp_vld, rsp_err, rsp_rdata,
        input  mmio_sel, mmio_wr_en, mmio_addr, mmio_wr_data
    );
endinterface

// File: rtl/risc_v_mike_mmio_arbiter.sv
// Round-robin arbiter sharing one MMIO port among N_REQ requesters.
// Ports: clk, rst (async, active-high), bus (interface, master modport).
module risc_v_mike_mmio_arbiter #(
    parameter int          N_REQ      = 2,
    parameter logic [31:0] MMIO_LIMIT = 32'h8
) (
    input logic clk,
    input logic rst,
    risc_v_mike_mmio_arbiter_if.master bus
);
    localparam int PTR_W = (N_REQ > 2) ? 2 : 1;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic             legal_q, legal_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             sel_q, sel_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             found;
    logic [PTR_W-1:0] win;
    int               cand;
    logic             win_we;
    logic [31:0]      win_addr;
    logic [31:0]      win_wdata;
    logic             win_legal;

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && bus.req_vld[cand]) begin
                found = 1'b1;
                win   = PTR_W'(cand);
            end
        end
    end

    assign win_we    = bus.req_we[win];
    assign win_addr  = bus.req_addr[int'(win)*32 +: 32];
    assign win_wdata = bus.req_wdata[int'(win)*32 +: 32];
    assign win_legal = (win_addr[1:0] == 2'b00) && (win_addr < MMIO_LIMIT);

    // Outputs for the next cycle are computed here so every strobe
    // leaves a flop; everything defaults to zero outside ACCESS/RESP.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        idx_d     = idx_q;
        we_d      = we_q;
        legal_d   = legal_q;
        gnt_d     = '0;
        rsp_vld_d = '0;
        rdata_d   = '0;
        sel_d     = 1'b0;
        wr_en_d   = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = ACCESS;
                    idx_d    = win;
                    we_d     = win_we;
                    legal_d  = win_legal;
                    gnt_d    = ONE << win;
                    rr_ptr_d = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                    if (win_legal) begin
                        sel_d   = 1'b1;
                        wr_en_d = win_we;
                        addr_d  = win_addr;
                        wdata_d = win_wdata;
                    end else if (!win_we) begin
                        // Rejected read answers in the grant cycle.
                        rsp_vld_d = ONE << win;
                    end
                end
            end
            ACCESS: begin
                if (legal_q && !we_q) begin
                    state_d   = RESP;
                    rsp_vld_d = ONE << idx_q;
                    rdata_d   = bus.mmio_rd_data;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            legal_q   <= 1'b0;
            gnt_q     <= '0;
            rsp_vld_q <= '0;
            rdata_q   <= '0;
            sel_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            legal_q   <= legal_d;
            gnt_q     <= gnt_d;
            rsp_vld_q <= rsp_vld_d;
            rdata_q   <= rdata_d;
            sel_q     <= sel_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.rsp_vld      = rsp_vld_q;
    assign bus.rsp_err      = (state_q == ACCESS) && !legal_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.mmio_sel     = sel_q;
    assign bus.mmio_wr_en   = wr_en_q;
    assign bus.mmio_addr    = addr_q;
    assign bus.mmio_wr_data = wdata_q;
endmodule
